rtlola_event_sequencer: RTL

//  Synthesizable, table-driven stimulus player for the RTLola monitor (topEntity).

---
 rtl/rtlola_seq_pkg.sv | 17 +
 rtl/rtlola_event_store.sv | 41 ++++
 rtl/rtlola_event_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rtlola_seq_pkg.sv
// Shared types and default sizing for the RTLola event sequencer.
package rtlola_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIRE = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_NUM_IN = 2;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_TS_W   = 32;
    localparam int unsigned FIRED_W    = 32;

endpackage

// File: rtl/rtlola_event_store.sv
// Event table: one synchronous write port, one asynchronous read port.
module rtlola_event_store
    import rtlola_seq_pkg::*;
#(
    parameter int unsigned NUM_IN = DEF_NUM_IN,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned TS_W   = DEF_TS_W
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [TS_W-1:0]            wts,
    input  logic [NUM_IN-1:0]          wmask,
    input  logic [NUM_IN*DATA_W-1:0]   wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [TS_W-1:0]            rts,
    output logic [NUM_IN-1:0]          rmask,
    output logic [NUM_IN*DATA_W-1:0]   rdata
);

    typedef struct packed {
        logic [TS_W-1:0]          ts;
        logic [NUM_IN-1:0]        mask;
        logic [NUM_IN*DATA_W-1:0] data;
    } entry_t;

    // Contents are deliberately not reset; the loader owns them.
    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= '{ts: wts, mask: wmask, data: wdata};
        end
    end

    assign rts   = mem[raddr].ts;
    assign rmask = mem[raddr].mask;
    assign rdata = mem[raddr].data;

endmodule

// File: rtl/rtlola_event_sequencer.sv
// Table-driven timed stimulus player feeding the RTLola monitor input ports.
module rtlola_event_sequencer
    import rtlola_seq_pkg::*;
#(
    parameter int unsigned NUM_IN = DEF_NUM_IN,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned TS_W   = DEF_TS_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       load_we,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [TS_W-1:0]            load_ts,
    input  logic [NUM_IN-1:0]          load_mask,
    input  logic [NUM_IN*DATA_W-1:0]   load_data,
    input  logic [$clog2(DEPTH):0]     num_events,
    input  logic                       loop_mode,
    input  logic                       start,
    input  logic                       abort,
    output logic [NUM_IN*DATA_W-1:0]   input_data,
    output logic [NUM_IN-1:0]          new_input,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   evt_idx,
    output logic [FIRED_W-1:0]         fired_count,
    output seq_state_t                 dbg_state
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned NUM_W = IDX_W + 1;

    seq_state_t               state_q, state_d;
    logic [TS_W-1:0]          cnt_q;
    logic [IDX_W-1:0]         idx_q, next_idx, rd_addr;
    logic [NUM_W-1:0]         num_q, num_clamped;
    logic [TS_W-1:0]          rd_ts;
    logic [NUM_IN-1:0]        rd_mask, strobe_q;
    logic [NUM_IN*DATA_W-1:0] rd_data, rd_masked, data_q;
    logic [FIRED_W-1:0]       fired_q;
    logic                     idle_like, is_last, rd_short, store_we;

    assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign store_we    = en && load_we && idle_like && !start;
    assign is_last     = ({1'b0, idx_q} + NUM_W'(1)) == num_q;
    assign next_idx    = is_last ? '0 : idx_q + IDX_W'(1);
    assign rd_short    = rd_ts <= TS_W'(1);
    assign num_clamped = (num_events > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : num_events;

    // The read port looks at whichever entry the next pulse will come from.
    always_comb begin
        rd_addr = '0;
        if (state_q == S_FIRE)      rd_addr = next_idx;
        else if (state_q == S_WAIT) rd_addr = idx_q;
    end

    always_comb begin
        rd_masked = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (rd_mask[k]) rd_masked[k*DATA_W +: DATA_W] = rd_data[k*DATA_W +: DATA_W];
        end
    end

    rtlola_event_store #(
        .NUM_IN(NUM_IN), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (load_addr),
        .wts   (load_ts),
        .wmask (load_mask),
        .wdata (load_data),
        .raddr (rd_addr),
        .rts   (rd_ts),
        .rmask (rd_mask),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    state_q <= S_IDLE;
        else if (en) state_q <= state_d;
    end

    // FIRE is the pulse cycle itself, so a delta of 0/1 must skip WAIT entirely.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) begin
                    if (num_clamped == '0) state_d = S_DONE;
                    else                   state_d = rd_short ? S_FIRE : S_WAIT;
                end
                S_WAIT: if (cnt_q <= TS_W'(1)) state_d = S_FIRE;
                S_FIRE: begin
                    if (is_last && !loop_mode) state_d = S_DONE;
                    else                       state_d = rd_short ? S_FIRE : S_WAIT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            num_q    <= '0;
            fired_q  <= '0;
            strobe_q <= '0;
            data_q   <= '0;
        end else if (en) begin
            strobe_q <= (state_d == S_FIRE) ? rd_mask : '0;
            data_q   <= (state_d == S_FIRE) ? rd_masked : '0;
            if (abort) begin
                cnt_q   <= '0;
                idx_q   <= '0;
                num_q   <= '0;
                fired_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: if (start) begin
                        num_q   <= num_clamped;
                        idx_q   <= '0;
                        fired_q <= '0;
                        cnt_q   <= rd_short ? '0 : rd_ts - TS_W'(1);
                    end
                    S_WAIT: cnt_q <= cnt_q - TS_W'(1);
                    S_FIRE: begin
                        fired_q <= fired_q + FIRED_W'(1);
                        if (state_d != S_DONE) begin
                            idx_q <= next_idx;
                            cnt_q <= rd_short ? '0 : rd_ts - TS_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy      = (state_q == S_WAIT) || (state_q == S_FIRE);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

    assign input_data  = data_q;
    assign new_input   = strobe_q;
    assign evt_idx     = idx_q;
    assign fired_count = fired_q;

endmodule
